// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter for 2^SIZE requesters. It keeps an encoded grant
// register and a rotating priority pointer, and drives a 1-hot grant vector
// through an N-to-2^N decoder. A grant ends on explicit release, on implicit
// release (the holder drops req) or when the hold watchdog expires.
// The release input is named release_req because "release" is a reserved word.

// N-to-2^N 1-hot decoder; the output is all-zero while en is low.
module onehot_decoder #(
  parameter int N = 2
) (
  input  logic [N-1:0]      in,
  input  logic              en,
  output logic [(1<<N)-1:0] out
);

  // Set exactly one bit when enabled, otherwise drive all-zero.
  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

module rr_grant_arbiter #(
  parameter int SIZE     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [(1<<SIZE)-1:0]              req,
  input  logic                              release_req,
  output logic                              grant_valid,
  output logic [SIZE-1:0]                   grant_id,
  output logic [(1<<SIZE)-1:0]              grant,
  output logic [$clog2(MAX_HOLD+1)-1:0]     hold_cnt,
  output logic                              timeout
);

  localparam int NREQ = 1 << SIZE;
  localparam int CW   = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  // FSM is implied by grant_valid: IDLE when 0, BUSY when 1.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic            grant_valid_q, grant_valid_d;
  logic [SIZE-1:0] grant_id_q,    grant_id_d;
  logic [SIZE-1:0] ptr_q,         ptr_d;
  logic [CW-1:0]   hold_cnt_q,    hold_cnt_d;
  logic            timeout_q,     timeout_d;

  logic [SIZE-1:0] win_id;
  logic            holder_req;
  logic            hold_expired;
  logic            grant_end;
  logic            others_pending;
  logic            watchdog_hit;

  // First requesting index scanning p, p+1, ... with natural SIZE-bit wrap.
  function automatic logic [SIZE-1:0] win(input logic [SIZE-1:0] p,
                                          input logic [NREQ-1:0] r);
    logic [SIZE-1:0] idx;
    logic            found;
    win   = p;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = p + SIZE'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Decode the registered holder into the 1-hot grant vector.
  onehot_decoder #(.N(SIZE)) u_dec (
    .in  (grant_id_q),
    .en  (grant_valid_q),
    .out (grant)
  );

  // Arbitration winner and end-of-grant conditions for the current holder.
  always_comb begin
    win_id         = win(ptr_q, req);
    holder_req     = req[grant_id_q];
    hold_expired   = (hold_cnt_q == HOLD_LAST);
    grant_end      = release_req || !holder_req || hold_expired;
    others_pending = |(req & ~grant);
    // The watchdog only counts as the cause when the holder neither released
    // explicitly nor dropped its request.
    watchdog_hit   = hold_expired && !release_req && holder_req;
  end

  // Next-state logic: grant, hand over, re-grant on timeout, or go idle.
  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
    if (grant_valid_q == ST_IDLE) begin
      hold_cnt_d = '0;
      if (|req) begin
        grant_valid_d = ST_BUSY;
        grant_id_d    = win_id;
        ptr_d         = win_id + SIZE'(1);
      end
    end else if (!grant_end) begin
      hold_cnt_d = hold_expired ? HOLD_LAST : hold_cnt_q + CW'(1);
    end else if (others_pending) begin
      // Direct hand-over with no idle bubble; the old holder sits last in
      // the scan because ptr already points past it.
      grant_id_d = win_id;
      ptr_d      = win_id + SIZE'(1);
      hold_cnt_d = '0;
      timeout_d  = watchdog_hit;
    end else if (watchdog_hit) begin
      // Nobody else is waiting, so the revoked holder gets a fresh grant.
      hold_cnt_d = '0;
      timeout_d  = 1'b1;
    end else begin
      grant_valid_d = ST_IDLE;
      hold_cnt_d    = '0;
    end
  end

  // Registered state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_valid_q <= ST_IDLE;
      grant_id_q    <= '0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign hold_cnt    = hold_cnt_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 2^SIZE requesters.
- Holds an encoded grant register and drives a 1-hot grant vector using the team's N-to-2^N 1-hot decoder, instantiated with `en = grant_valid`.
- Placed in front of shared datapath resources (register-file write port, bus master slot) so that exactly one requester owns the resource at a time.
- Supports explicit release, implicit release and a hold-timeout watchdog.

Parameters:
- SIZE, 2, log2 of the requester count.
- NREQ, 1<<SIZE, number of requesters. Derived; do not override.
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced re-arbitration. Must be >= 1.
- CW, $clog2(MAX_HOLD+1), width of the hold counter. Derived.

Ports:
- clk, input, 1, clock. All state changes on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- req, input, NREQ, per-requester request level.
- release, input, 1, the current holder gives up the grant. Ignored when grant_valid=0.
- grant_valid, output, 1, the resource is currently granted.
- grant_id, output, SIZE, encoded index of the holder. Valid only when grant_valid=1.
- grant, output, NREQ, 1-hot grant. All-zero when grant_valid=0.
- hold_cnt, output, CW, number of cycles the current grant has been held (0 on the first grant cycle).
- timeout, output, 1, single-cycle pulse when a grant is revoked because of MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant_valid=0, grant_id=0, grant=0, hold_cnt=0, timeout=0.
  - Priority pointer ptr=0.
  - Reset mid-grant drops the grant on that edge; no release handshake is required.
- State machine:
  - IDLE when grant_valid=0.
  - BUSY when grant_valid=1.
- Arbitration function win(ptr, req): the first index i, scanning ptr, ptr+1, ..., ptr+NREQ-1 with mod NREQ wrap, for which req[i]=1.
- IDLE:
  - If |req, go to BUSY next cycle with grant_id=win(ptr,req), ptr=grant_id+1 (mod NREQ, natural SIZE-bit wrap) and hold_cnt=0.
  - Latency from req rising to grant is 1 cycle.
- BUSY, end-of-grant condition:
  - end = release OR ~req[grant_id] (implicit release) OR (hold_cnt == MAX_HOLD-1) (timeout).
- BUSY with end=0: hold grant_id and ptr; hold_cnt increments and saturates at MAX_HOLD-1.
- BUSY with end=1 and another requester pending (|(req & ~grant)):
  - Go directly to a new grant next cycle: grant_id=win(ptr,req), ptr updated, hold_cnt=0.
  - There is no idle bubble.
  - The previous holder's req is included in this scan but has lowest priority, because ptr already points past it.
- BUSY with end=1 and no other requester pending:
  - Explicit release or implicit release: go to IDLE.
  - Timeout while the same holder still requests: re-grant the same holder next cycle (grant_valid stays 1, hold_cnt=0).
- timeout=1 on the cycle after the edge where the timeout condition was taken. It is a registered pulse lasting exactly 1 cycle.
- Simultaneous events:
  - release and timeout in the same cycle: treated as release, timeout=0.
  - New req arriving in the same cycle as release: eligible in that cycle's scan.
- Guaranteed properties:
  - grant is always 1-hot or zero.
  - Every continuously asserting requester is granted within NREQ*MAX_HOLD + NREQ cycles (starvation-free).
- Outputs grant_valid, grant_id, hold_cnt and timeout are registered. grant is combinational from the registered grant_id and grant_valid through the decoder.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0 for 2 cycles, then req=0.
  - Required response: grant=0000, grant_valid=0, hold_cnt=0, timeout=0 on every cycle.
- Single requester:
  - Stimulus: req=0100 at cycle 0; release=1 at cycle 3.
  - Required response: grant=0100, grant_id=2 from cycle 1; hold_cnt counts 0,1,2; grant=0000 at cycle 4.
- Round-robin fairness:
  - Stimulus: req=1111 held, release pulsed every 2nd grant cycle, starting from reset.
  - Required response: grant_id sequence 0,1,2,3,0 with no idle cycle between grants.
- Timeout (MAX_HOLD=8):
  - Stimulus: req=0011, release never asserted.
  - Required response: id0 granted for exactly 8 cycles, timeout=1 for 1 cycle, then id1 granted. With req=0001 only, id0 is re-granted with hold_cnt=0.
- Implicit release and wrap:
  - Stimulus: holder id3 drops req; req[0]=1 and req[2]=1.
  - Required response: next grant_id=0 (ptr wrapped from 3 to 0), not 2.
- Reset mid-grant:
  - Stimulus: rst_n=0 asserted while grant_id=1 is held.
  - Required response: grant=0000 on the following cycle and ptr=0, so req=1111 after reset grants id0 first.
